// File: rtl/sram_controller.sv
// SRAM controller: 64-bit line reads and 32-bit word writes over a 16-bit
// SRAM bus, with a configurable number of wait cycles per halfword.
module sram_controller #(
  parameter int unsigned SRAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdEn,
  input  logic        wrEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [63:0] readData,
  output logic        ready,
  output logic [17:0] sramAddr,
  output logic [15:0] sramDqOut,
  input  logic [15:0] sramDqIn,
  output logic        sramDqOe,
  output logic        sramWeN
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [1:0]  hw, hw_n;
  logic [2:0]  wcnt, wcnt_n;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;
  logic        last_wait;
  logic        last_hw;
  logic        unused_ok;

  assign unused_ok = ^{address[31:19], address[1:0]};

  assign last_wait = (wcnt == 3'(SRAM_WAIT));
  assign last_hw   = (state == READ) ? (hw == 2'd3) : hw[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hw       <= '0;
      wcnt     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      readData <= '0;
    end else begin
      state <= state_n;
      hw    <= hw_n;
      wcnt  <= wcnt_n;
      if (state == IDLE && (rdEn || wrEn)) begin
        addr_q  <= address[18:2];
        wdata_q <= writeData;
      end
      // capture on the final cycle of each access, once data has settled
      if (state == READ && last_wait)
        readData[{hw, 4'b0} +: 16] <= sramDqIn;
    end
  end

  always_comb begin
    state_n   = state;
    hw_n      = hw;
    wcnt_n    = wcnt;
    ready     = 1'b0;
    sramAddr  = '0;
    sramDqOut = '0;
    sramDqOe  = 1'b0;
    sramWeN   = 1'b1;
    unique case (state)
      IDLE: begin
        ready  = !rst && !rdEn && !wrEn;
        hw_n   = '0;
        wcnt_n = '0;
        if (wrEn)
          state_n = WRITE;
        else if (rdEn)
          state_n = READ;
      end
      READ: begin
        sramAddr = {addr_q[16:1], hw};
      end
      WRITE: begin
        sramAddr  = {addr_q, hw[0]};
        sramDqOut = hw[0] ? wdata_q[31:16] : wdata_q[15:0];
        sramDqOe  = 1'b1;
        sramWeN   = 1'b0;
      end
      DONE: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
    endcase
    if (state == READ || state == WRITE) begin
      if (last_wait) begin
        wcnt_n = '0;
        if (last_hw) begin
          state_n = DONE;
          hw_n    = '0;
        end else begin
          hw_n = hw + 2'd1;
        end
      end else begin
        wcnt_n = wcnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: one instance with SRAM_WAIT=1,
// one with SRAM_WAIT=0, each isolated by holding the other in reset.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1;
  logic        rst1 = 1'b1;
  logic        rdEn = 1'b0;
  logic        wrEn = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;

  logic [63:0] rd0, rd1;
  logic        rdy0, rdy1;
  logic [17:0] a0, a1;
  logic [15:0] do0, do1, di0, di1;
  logic        oe0, oe1, we0, we1;

  bit [15:0] wmem [0:3];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_at = 0;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] dq;
    logic        weN;
    logic        oe;
    logic        rdy;
  } bus_t;

  bus_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller #(.SRAM_WAIT(0)) u_w0 (
    .clk(clk), .rst(rst0), .rdEn(rdEn), .wrEn(wrEn),
    .address(address), .writeData(writeData),
    .readData(rd0), .ready(rdy0), .sramAddr(a0),
    .sramDqOut(do0), .sramDqIn(di0),
    .sramDqOe(oe0), .sramWeN(we0)
  );

  sram_controller #(.SRAM_WAIT(1)) u_w1 (
    .clk(clk), .rst(rst1), .rdEn(rdEn), .wrEn(wrEn),
    .address(address), .writeData(writeData),
    .readData(rd1), .ready(rdy1), .sramAddr(a1),
    .sramDqOut(do1), .sramDqIn(di1),
    .sramDqOe(oe1), .sramWeN(we1)
  );

  function automatic logic [15:0] pat(input logic [17:0] a);
    if (a >= 18'h204 && a <= 18'h207)
      return 16'h1111 * 16'(a - 18'h203);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [63:0] line(input logic [31:0] a);
    return {pat({a[18:3], 2'd3}), pat({a[18:3], 2'd2}),
            pat({a[18:3], 2'd1}), pat({a[18:3], 2'd0})};
  endfunction

  // SRAM model: halfwords 8..11 are writable, the rest is a fixed pattern
  assign di0 = pat(a0);
  assign di1 = (a1 >= 18'd8 && a1 <= 18'd11) ? wmem[a1[1:0]] : pat(a1);

  always @(negedge clk)
    if (!we1 && a1 >= 18'd8 && a1 <= 18'd11)
      wmem[a1[1:0]] <= do1;

  function automatic bus_t obs(input bit w);
    return w ? bus_t'({a1, do1, we1, oe1, rdy1})
             : bus_t'({a0, do0, we0, oe0, rdy0});
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xact(input bit w, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] a_next,
                      input bit rd_next, input logic [63:0] erd);
    int   per;
    int   n;
    logic [1:0] k;
    bus_t e;
    per = w ? 2 : 1;
    n = (wr ? 2 : 4) * per;
    for (int c = 0; c < n; c++) begin
      k = 2'(c / per);
      e.addr = wr ? {a[18:2], k[0]} : {a[18:3], k};
      e.dq   = wr ? (k[0] ? d[31:16] : d[15:0]) : 16'h0;
      e.weN  = !wr;
      e.oe   = wr;
      e.rdy  = 1'b0;
      exp_q.push_back(e);
    end
    e = '{addr: 18'h0, dq: 16'h0, weN: 1'b1, oe: 1'b0, rdy: 1'b1};
    exp_q.push_back(e);
    #1;
    chk("req_ready", {63'h0, (w ? rdy1 : rdy0)}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rdEn = rd_next;
    wrEn = 1'b0;
    address = a_next;
    writeData = ~d;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) @(negedge clk);
      e = exp_q.pop_front();
      chk(wr ? "wr_bus" : "rd_bus", 64'(obs(w)), 64'(e));
    end
    done_at = cyc;
    if (!wr) chk("rd_line", w ? rd1 : rd0, erd);
  endtask

  initial begin
    int first_done;
    repeat (2) @(negedge clk);
    chk("rst_bus1", 64'(obs(1)), 64'({18'h0, 16'h0, 3'b100}));
    chk("rst_bus0", 64'(obs(0)), 64'({18'h0, 16'h0, 3'b100}));
    chk("rst_line", rd1, 64'h0);
    rst1 = 1'b0;
    #1;
    chk("idle_ready", {63'h0, rdy1}, 64'h1);

    @(negedge clk);
    rdEn = 1'b1;
    address = 32'h0000_0408;
    xact(1, 0, 32'h408, 32'h0, 32'h408, 0, 64'h4444_3333_2222_1111);
    @(negedge clk);
    #1;
    chk("idle_ready2", {63'h0, rdy1}, 64'h1);
    chk("line_hold", rd1, 64'h4444_3333_2222_1111);

    wrEn = 1'b1;
    address = 32'h0000_0404;
    writeData = 32'hDEAD_BEEF;
    xact(1, 1, 32'h404, 32'hDEAD_BEEF, 32'h404, 0, 64'h0);
    chk("line_hold_wr", rd1, 64'h4444_3333_2222_1111);

    @(negedge clk);
    rdEn = 1'b1;
    wrEn = 1'b1;
    address = 32'h0000_0010;
    writeData = 32'hCAFE_F00D;
    xact(1, 1, 32'h10, 32'hCAFE_F00D, 32'h10, 1, 64'h0);
    @(negedge clk);
    xact(1, 0, 32'h10, 32'h0, 32'h10, 0, 64'h0000_0000_CAFE_F00D);

    @(negedge clk);
    rdEn = 1'b1;
    address = 32'h0000_0408;
    #1;
    chk("rst_req_ready", {63'h0, rdy1}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rdEn = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_addr", {46'h0, a1}, 64'h206);
    rst1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_bus", 64'(obs(1)), 64'({18'h0, 16'h0, 3'b100}));
      chk("midrst_line", rd1, 64'h0);
    end
    rst1 = 1'b0;
    #1;
    chk("post_rst_ready", {63'h0, rdy1}, 64'h1);

    @(negedge clk);
    rst1 = 1'b1;
    rst0 = 1'b0;
    @(negedge clk);
    rdEn = 1'b1;
    address = 32'h0000_0408;
    xact(0, 0, 32'h408, 32'h0, 32'h0007_0A38, 1, line(32'h408));
    first_done = done_at;
    @(negedge clk);
    xact(0, 0, 32'h0007_0A38, 32'h0, 32'h0007_0A38, 0,
         line(32'h0007_0A38));
    chk("ready_period", 64'(done_at - first_done), 64'd6);
    @(negedge clk);
    #1;
    chk("idle_ready0", {63'h0, rdy0}, 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
